// File: rtl/cfg_bitstream_pkg.sv
// Shared opcodes, sync word, CRC polynomial and FSM state encoding for the
// LIFCL configuration bitstream reader.
package cfg_bitstream_pkg;

  localparam logic [31:0] PREAMBLE = 32'hFFFF_BDB3;
  localparam logic [15:0] CRC_POLY = 16'h8005;

  localparam logic [7:0] OP_NOOP          = 8'hFF;
  localparam logic [7:0] OP_VERIFY_ID     = 8'hE2;
  localparam logic [7:0] OP_INIT_ADDRESS  = 8'h46;
  localparam logic [7:0] OP_WRITE_ADDRESS = 8'hB4;
  localparam logic [7:0] OP_PROG_INCR_RTI = 8'h82;
  localparam logic [7:0] OP_RESET_CRC     = 8'h3B;
  localparam logic [7:0] OP_PROGRAM_DONE  = 8'h5E;

  typedef enum logic [2:0] {HUNT, CMD, ARGS, PAYLOAD, DATA, CRC2, PAD} state_t;

endpackage

// File: rtl/crc16_byte.sv
// One-byte step of CRC-16 (poly 0x8005, MSB first, no reflection).
module crc16_byte
  import cfg_bitstream_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[15] ^ data[i]) crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      else                       crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/cfg_bitstream_reader.sv
// Byte-serial config bitstream decoder: preamble hunt, command decode, and
// zero-latency forwarding of frame data bytes with per-frame CRC check.
module cfg_bitstream_reader
  import cfg_bitstream_pkg::*;
#(
  parameter int FRAME_BYTES = 40,
  parameter int ADDR_W      = 16,
  parameter int MAX_FRAMES  = 4096,
  localparam int IDX_W      = $clog2(FRAME_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [ADDR_W-1:0] frm_addr,
  output logic [IDX_W-1:0]  frm_idx,
  output logic [7:0]        frm_data,
  output logic              frm_last,
  output logic [31:0]       idcode,
  output logic              synced,
  output logic              done,
  output logic              crc_err,
  output logic              cmd_err
);

  localparam int BCW = $clog2((FRAME_BYTES > 4) ? FRAME_BYTES : 4);
  localparam int FCW = $clog2(MAX_FRAMES + 1);

  state_t          state;
  logic [23:0]     shift;
  logic [7:0]      opcode;
  logic [15:0]     operand;   // only the low 16 operand bits are ever consumed
  logic [23:0]     payload;
  logic [BCW-1:0]  bcnt;
  logic [FCW-1:0]  fcnt;
  logic [15:0]     nfr;
  logic [15:0]     crc;
  logic [7:0]      crc_hi;
  logic [15:0]     crc_next;
  logic [15:0]     operand_nxt;
  logic [31:0]     payload_nxt;
  logic            in_data_st;
  logic            acc;

  crc16_byte u_crc (.crc_in(crc), .data(in_data), .crc_out(crc_next));

  assign in_data_st  = (state == DATA);
  assign in_ready    = in_data_st ? frm_ready : 1'b1;
  assign acc         = in_valid & in_ready;
  assign frm_valid   = in_data_st & in_valid;
  assign frm_data    = in_data_st ? in_data : 8'h00;
  assign frm_idx     = in_data_st ? IDX_W'(bcnt) : '0;
  assign frm_last    = in_data_st && (bcnt == BCW'(FRAME_BYTES - 1));
  assign operand_nxt = {operand[7:0], in_data};
  assign payload_nxt = {payload, in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      shift    <= '0;
      opcode   <= '0;
      operand  <= '0;
      payload  <= '0;
      bcnt     <= '0;
      fcnt     <= '0;
      nfr      <= '0;
      crc      <= '0;
      crc_hi   <= '0;
      frm_addr <= '0;
      idcode   <= '0;
      synced   <= 1'b0;
      done     <= 1'b0;
      crc_err  <= 1'b0;
      cmd_err  <= 1'b0;
    end else if (acc) begin
      unique case (state)
        HUNT: begin
          shift <= {shift[15:0], in_data};
          if ({shift, in_data} == PREAMBLE) begin
            state  <= CMD;
            synced <= 1'b1;
            shift  <= '0;
          end
        end
        CMD: begin
          bcnt   <= '0;
          opcode <= in_data;
          case (in_data)
            OP_NOOP: state <= CMD;
            OP_VERIFY_ID, OP_INIT_ADDRESS, OP_WRITE_ADDRESS,
            OP_PROG_INCR_RTI, OP_RESET_CRC, OP_PROGRAM_DONE: state <= ARGS;
            default: begin
              cmd_err <= 1'b1;
              synced  <= 1'b0;
              state   <= HUNT;
            end
          endcase
        end
        ARGS: begin
          operand <= operand_nxt;
          bcnt    <= bcnt + BCW'(1);
          if (bcnt == BCW'(2)) begin
            bcnt <= '0;
            case (opcode)
              OP_VERIFY_ID, OP_WRITE_ADDRESS: state <= PAYLOAD;
              OP_INIT_ADDRESS: begin frm_addr <= '0; state <= CMD; end
              OP_RESET_CRC:    begin crc <= '0;      state <= CMD; end
              OP_PROG_INCR_RTI: begin
                if (operand_nxt == 16'd0 || 32'(operand_nxt) > 32'(MAX_FRAMES)) begin
                  cmd_err <= 1'b1;
                  synced  <= 1'b0;
                  state   <= HUNT;
                end else begin
                  nfr   <= operand_nxt;
                  fcnt  <= '0;
                  state <= DATA;
                end
              end
              OP_PROGRAM_DONE: begin
                done   <= 1'b1;
                synced <= 1'b0;
                state  <= HUNT;
              end
              default: state <= CMD;
            endcase
          end
        end
        PAYLOAD: begin
          payload <= payload_nxt[23:0];
          bcnt    <= bcnt + BCW'(1);
          if (bcnt == BCW'(3)) begin
            bcnt  <= '0;
            state <= CMD;
            if (opcode == OP_VERIFY_ID) idcode   <= payload_nxt;
            else                        frm_addr <= payload_nxt[ADDR_W-1:0];
          end
        end
        DATA: begin
          crc <= crc_next;
          if (bcnt == BCW'(FRAME_BYTES - 1)) begin
            bcnt  <= '0;
            state <= CRC2;
          end else begin
            bcnt <= bcnt + BCW'(1);
          end
        end
        CRC2: begin
          if (bcnt == '0) begin
            crc_hi <= in_data;
            bcnt   <= BCW'(1);
          end else begin
            if ({crc_hi, in_data} != crc) crc_err <= 1'b1;
            bcnt  <= '0;
            state <= PAD;
          end
        end
        PAD: begin
          // a bad frame still advances the address and the frame count
          frm_addr <= frm_addr + ADDR_W'(1);
          crc      <= '0;
          if (16'(fcnt) + 16'd1 == nfr) begin
            state <= CMD;
          end else begin
            fcnt  <= fcnt + FCW'(1);
            state <= DATA;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bitstream_reader.sv
// Directed bench for cfg_bitstream_reader: table-driven ID decode plus
// hand-written frame, stall, error and reset sequences.
module tb_cfg_bitstream_reader;

  localparam int FB   = 40;
  localparam int AW   = 16;
  localparam int MAXF = 4096;
  localparam int IW   = $clog2(FB);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          frm_valid;
  logic          frm_ready;
  logic [AW-1:0] frm_addr;
  logic [IW-1:0] frm_idx;
  logic [7:0]    frm_data;
  logic          frm_last;
  logic [31:0]   idcode;
  logic          synced, done, crc_err, cmd_err;

  cfg_bitstream_reader #(.FRAME_BYTES(FB), .ADDR_W(AW), .MAX_FRAMES(MAXF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_addr(frm_addr), .frm_idx(frm_idx),
    .frm_data(frm_data), .frm_last(frm_last), .idcode(idcode), .synced(synced),
    .done(done), .crc_err(crc_err), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] idx;
    logic [7:0]    data;
    logic          last;
  } fb_t;

  typedef struct {
    logic [7:0]  b;
    logic        synced;
    logic [31:0] id;
    logic        cerr;
  } vec_t;

  fb_t  exp_q[$];
  fb_t  got_q[$];
  int   checks = 0;
  int   errors = 0;
  logic stall_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Augmented-message long division; equivalent to a direct CRC with init 0.
  function automatic logic [15:0] crc_ref(input logic [7:0] d[FB]);
    logic [15:0] r = 16'h0;
    logic        top;
    for (int i = 0; i < FB + 2; i++)
      for (int b = 7; b >= 0; b--) begin
        top = r[15];
        r   = {r[14:0], (i < FB) ? d[i][b] : 1'b0};
        if (top) r = r ^ 16'h8005;
      end
    return r;
  endfunction

  // Drive one byte from a negedge, hold until handshake, log forwarded bytes.
  task automatic send(input logic [7:0] b);
    int  n = 0;
    fb_t e;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      frm_ready = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
      #1;
      if (frm_valid && !frm_ready && got_q.size() < exp_q.size())
        chk("stall_addr_idx", {frm_addr, frm_idx},
            {exp_q[got_q.size()].addr, exp_q[got_q.size()].idx});
      if (in_ready) begin
        if (frm_valid) begin
          e.addr = frm_addr; e.idx = frm_idx; e.data = frm_data; e.last = frm_last;
          got_q.push_back(e);
        end
        @(negedge clk);
        break;
      end
      n++;
      if (n > 200) begin
        chk("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    frm_ready = 1'b1;
  endtask

  task automatic send_pre();
    send(8'hFF); send(8'hFF); send(8'hBD); send(8'hB3);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [23:0] arg);
    send(op); send(arg[23:16]); send(arg[15:8]); send(arg[7:0]);
  endtask

  task automatic send_frame(input int mul, input int add, input logic flip);
    logic [7:0]  d[FB];
    logic [15:0] c;
    for (int i = 0; i < FB; i++) d[i] = 8'(i * mul + add);
    c = crc_ref(d);
    if (flip) c[7:0] = ~c[7:0];
    for (int i = 0; i < FB; i++) send(d[i]);
    send(c[15:8]); send(c[7:0]); send(8'hFF);
  endtask

  task automatic exp_frame(input logic [AW-1:0] a, input int mul, input int add);
    fb_t e;
    for (int i = 0; i < FB; i++) begin
      e.addr = a; e.idx = IW'(i); e.data = 8'(i * mul + add); e.last = (i == FB - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_q(input string name);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_byte"},
          {got_q[i].addr, got_q[i].idx, got_q[i].data, got_q[i].last},
          {exp_q[i].addr, exp_q[i].idx, exp_q[i].data, exp_q[i].last});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; frm_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tv[14];

  initial begin
    tv[0]  = '{8'hAA, 1'b0, 32'h0, 1'b0};
    tv[1]  = '{8'hFF, 1'b0, 32'h0, 1'b0};
    tv[2]  = '{8'hFF, 1'b0, 32'h0, 1'b0};
    tv[3]  = '{8'hBD, 1'b0, 32'h0, 1'b0};
    tv[4]  = '{8'hB3, 1'b1, 32'h0, 1'b0};
    tv[5]  = '{8'hFF, 1'b1, 32'h0, 1'b0};
    tv[6]  = '{8'hE2, 1'b1, 32'h0, 1'b0};
    tv[7]  = '{8'h00, 1'b1, 32'h0, 1'b0};
    tv[8]  = '{8'h00, 1'b1, 32'h0, 1'b0};
    tv[9]  = '{8'h00, 1'b1, 32'h0, 1'b0};
    tv[10] = '{8'h01, 1'b1, 32'h0, 1'b0};
    tv[11] = '{8'h11, 1'b1, 32'h0, 1'b0};
    tv[12] = '{8'h10, 1'b1, 32'h0, 1'b0};
    tv[13] = '{8'h43, 1'b1, 32'h0111_1043, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; frm_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", {in_ready, frm_valid, frm_addr, frm_idx, frm_data, frm_last,
                        synced, done, crc_err, cmd_err},
        {1'b1, 1'b0, 16'h0, 6'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_idcode", idcode, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      send(tv[i].b);
      chk("tv_synced", synced, tv[i].synced);
      chk("tv_idcode", idcode, tv[i].id);
      chk("tv_cmd_err", cmd_err, tv[i].cerr);
    end

    // Two good frames from address 0.
    send_cmd(8'h46, 24'h0); send_cmd(8'h82, 24'h000002);
    exp_frame(16'h0, 1, 0); exp_frame(16'h1, 1, 0);
    send_frame(1, 0, 1'b0); send_frame(1, 0, 1'b0);
    compare_q("good");
    chk("good_crc_err", crc_err, 1'b0);
    chk("good_flags", {synced, cmd_err, done}, 3'b100);

    // First frame CRC low byte corrupted; second still emitted at addr 1.
    send_cmd(8'h46, 24'h0); send_cmd(8'h82, 24'h000002);
    exp_frame(16'h0, 1, 0); exp_frame(16'h1, 1, 0);
    send_frame(1, 0, 1'b1);
    chk("bad_crc_err", crc_err, 1'b1);
    send_frame(1, 0, 1'b0);
    compare_q("badcrc");

    // Stalled output, address wrap from 0xFFFF.
    stall_en = 1'b1;
    send_cmd(8'hB4, 24'h0); send(8'h00); send(8'h00); send(8'hFF); send(8'hFF);
    send_cmd(8'h82, 24'h000002);
    exp_frame(16'hFFFF, 7, 3); exp_frame(16'h0000, 7, 3);
    send_frame(7, 3, 1'b0); send_frame(7, 3, 1'b0);
    stall_en = 1'b0;
    compare_q("stall");
    chk("pre_bad_op_cmd_err", cmd_err, 1'b0);

    send(8'h99);
    chk("bad_op", {cmd_err, synced}, 2'b10);
    send_pre(); send_cmd(8'h5E, 24'h0);
    chk("done", {done, synced}, 2'b10);

    // Reset in the middle of a frame.
    send_pre(); send_cmd(8'h46, 24'h0); send_cmd(8'h82, 24'h000001);
    for (int i = 0; i < 10; i++) send(8'(i));
    got_q.delete();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; frm_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_state", {in_ready, frm_valid, frm_addr, frm_idx, frm_data, frm_last,
                         synced, done, crc_err, cmd_err},
        {1'b1, 1'b0, 16'h0, 6'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("midrst_idcode", idcode, 32'h0);
    rst = 1'b0; in_valid = 1'b0; frm_ready = 1'b1;
    @(negedge clk);
    send_pre(); send_cmd(8'h82, 24'h000001);
    exp_frame(16'h0, 3, 1);
    send_frame(3, 1, 1'b0);
    compare_q("fresh");
    chk("fresh_flags", {crc_err, cmd_err, synced}, 3'b001);

    // Frame count boundaries.
    send_cmd(8'h82, 24'h000000);
    chk("n_zero", {cmd_err, synced}, 2'b10);
    do_reset();
    send_pre(); send_cmd(8'h82, 24'h001001);
    chk("n_over", {cmd_err, synced}, 2'b10);
    do_reset();
    send_pre(); send_cmd(8'h82, 24'h001000);
    chk("n_max", {cmd_err, synced}, 2'b01);
    send(8'hC3);
    chk("n_max_fwd", {got_q.size() == 1, got_q[0].data}, {1'b1, 8'hC3});
    got_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
